// File: rtl/serial_queue_pkg.sv
// Shared constants and types for the serial receive path and its byte queue.
package serial_queue_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 8;
   localparam int PTR_W      = $clog2(DEPTH);
   localparam int CNT_W      = $clog2(DEPTH) + 1;
   localparam int BIT_CNT_W  = $clog2(DATA_WIDTH) + 1;

   typedef logic [DATA_WIDTH-1:0] byte_t;
   typedef logic [PTR_W-1:0]      ptr_t;
   typedef logic [CNT_W-1:0]      cnt_t;
   typedef logic [BIT_CNT_W-1:0]  bit_cnt_t;

   localparam cnt_t     FIFO_FULL_CNT = cnt_t'(DEPTH);
   localparam bit_cnt_t BITS_PER_BYTE = bit_cnt_t'(DATA_WIDTH);

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue with an occupancy counter; a pop and a push in the
// same cycle are both honoured, so a full queue can accept while it drains.
module byte_fifo
   import serial_queue_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  byte_t push_data,
   input  logic  pop,
   output byte_t pop_data,
   output logic  full,
   output logic  empty
);

   byte_t mem_q [DEPTH];
   ptr_t  wr_ptr_q, wr_ptr_d;
   ptr_t  rd_ptr_q, rd_ptr_d;
   cnt_t  count_q, count_d;
   logic  do_push, do_pop;

   assign full     = (count_q == FIFO_FULL_CNT);
   assign empty    = (count_q == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; the pointers and count alone
   // decide which entries are valid, so clearing them empties the queue.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/serial_byte_queue.sv
// MSB-first bit deserializer feeding a byte queue; bytes are popped onto
// data_out by rising edges of dequeue_in.
module serial_byte_queue
   import serial_queue_pkg::*;
(
   input  logic                  clock1M,
   input  logic                  reset,
   input  logic                  data_in,
   input  logic                  write_in,
   input  logic                  dequeue_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  status_out
);

   logic     data_in_q, data_in_d;
   logic     write_in_q, write_in_d, write_prev_q, write_prev_d;
   logic     dequeue_in_q, dequeue_in_d, dequeue_prev_q, dequeue_prev_d;
   byte_t    shift_q, shift_d;
   bit_cnt_t bit_cnt_q, bit_cnt_d;
   logic     pending_q, pending_d;
   byte_t    data_out_q, data_out_d;

   logic     write_ev, deq_ev, take_bit, push_accept, status;
   byte_t    fifo_pop_data;
   logic     fifo_full, fifo_empty;

   // A blocked byte may leave in the same cycle a pop frees its slot.
   assign write_ev    = write_in_q & ~write_prev_q;
   assign deq_ev      = dequeue_in_q & ~dequeue_prev_q;
   assign status      = ~(pending_q & fifo_full);
   assign push_accept = pending_q & (~fifo_full | deq_ev);
   assign take_bit    = write_ev & status;

   // NOTE: every always_comb output gets its default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      data_in_d      = data_in;
      write_in_d     = write_in;
      write_prev_d   = write_in_q;
      dequeue_in_d   = dequeue_in;
      dequeue_prev_d = dequeue_in_q;
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      pending_d      = pending_q;
      data_out_d     = data_out_q;

      if (push_accept) begin
         bit_cnt_d = '0;
         pending_d = 1'b0;
      end
      if (take_bit) begin
         shift_d   = {shift_q[DATA_WIDTH-2:0], data_in_q};
         bit_cnt_d = bit_cnt_d + bit_cnt_t'(1);
         pending_d = (bit_cnt_d == BITS_PER_BYTE);
      end
      if (deq_ev && !fifo_empty) data_out_d = fifo_pop_data;
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         data_in_q      <= 1'b0;
         write_in_q     <= 1'b0;
         write_prev_q   <= 1'b0;
         dequeue_in_q   <= 1'b0;
         dequeue_prev_q <= 1'b0;
         shift_q        <= '0;
         bit_cnt_q      <= '0;
         pending_q      <= 1'b0;
         data_out_q     <= '0;
      end else begin
         data_in_q      <= data_in_d;
         write_in_q     <= write_in_d;
         write_prev_q   <= write_prev_d;
         dequeue_in_q   <= dequeue_in_d;
         dequeue_prev_q <= dequeue_prev_d;
         shift_q        <= shift_d;
         bit_cnt_q      <= bit_cnt_d;
         pending_q      <= pending_d;
         data_out_q     <= data_out_d;
      end
   end

   byte_fifo u_fifo (
      .clk       (clock1M),
      .rst_n     (reset),
      .push      (push_accept),
      .push_data (shift_q),
      .pop       (deq_ev),
      .pop_data  (fifo_pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign data_out   = data_out_q;
   assign status_out = status;

endmodule

// File: tb/tb_serial_byte_queue.sv
// Scenario bench for serial_byte_queue with a byte scoreboard.
`timescale 1ns/1ps
module tb_serial_byte_queue;
   import serial_queue_pkg::*;

   logic  clock1M    = 1'b0;
   logic  reset      = 1'b0;
   logic  data_in    = 1'b0;
   logic  write_in   = 1'b0;
   logic  dequeue_in = 1'b0;
   byte_t data_out;
   logic  status_out;

   int    n_checks = 0;
   int    n_fail   = 0;
   byte_t sb_q[$];
   byte_t exp_last = 8'h00;

   always #500 clock1M = ~clock1M;

   serial_byte_queue dut (
      .clock1M    (clock1M),
      .reset      (reset),
      .data_in    (data_in),
      .write_in   (write_in),
      .dequeue_in (dequeue_in),
      .data_out   (data_out),
      .status_out (status_out)
   );

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock1M);
   endtask

   task automatic send_bit(input logic b, input int hi, input int lo);
      @(negedge clock1M);
      data_in  = b;
      write_in = 1'b1;
      wait_cycles(hi);
      write_in = 1'b0;
      data_in  = 1'($urandom_range(0, 1));
      wait_cycles(lo);
   endtask

   task automatic send_byte(input byte_t v, input int hi, input bit record);
      for (int i = DATA_WIDTH - 1; i >= 0; i--) send_bit(v[i], hi, 10);
      if (record) sb_q.push_back(v);
   endtask

   // Pulses dequeue_in for one cycle; returns data_out one and two clocks
   // after the rise, plus status_out at the second sample.
   task automatic do_dequeue(output byte_t mid, output byte_t fin, output logic st);
      @(negedge clock1M);
      dequeue_in = 1'b1;
      @(negedge clock1M);
      mid = data_out;
      dequeue_in = 1'b0;
      @(negedge clock1M);
      fin = data_out;
      st  = status_out;
      wait_cycles(2);
   endtask

   function automatic byte_t sb_next();
      if (sb_q.size() > 0) exp_last = sb_q.pop_front();
      return exp_last;
   endfunction

   task automatic test_reset();
      byte_t mid, fin, prev, exp;
      logic  st;
      reset = 1'b0;
      wait_cycles(10);
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
      n_checks++;
      if (status_out !== 1'b1) begin n_fail++; $display("FAIL reset_status: got %b expected 1", status_out); end
      reset = 1'b1;
      wait_cycles(2);
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL post_reset_data_out: got %h expected 00", data_out); end
      prev = exp_last;
      exp  = sb_next();
      do_dequeue(mid, fin, st);
      n_checks++;
      if (fin !== exp || mid !== prev) begin
         n_fail++; $display("FAIL empty_dequeue_after_reset: got %h/%h expected %h/%h", mid, fin, prev, exp);
      end
   endtask

   task automatic test_byte_order();
      byte_t mid, fin, prev, exp;
      logic  st;
      send_byte(8'hA5, 10, 1'b1);
      send_byte(8'h3C, 10, 1'b1);
      wait_cycles(5);
      for (int i = 0; i < 3; i++) begin
         prev = exp_last;
         exp  = sb_next();
         do_dequeue(mid, fin, st);
         n_checks++;
         if (mid !== prev) begin n_fail++; $display("FAIL order_latency[%0d]: got %h expected %h", i, mid, prev); end
         n_checks++;
         if (fin !== exp) begin n_fail++; $display("FAIL order_data[%0d]: got %h expected %h", i, fin, exp); end
      end
   endtask

   task automatic test_long_strobe();
      byte_t mid, fin, exp;
      logic  st;
      send_byte(8'hF0, 50, 1'b1);
      n_checks++;
      if (status_out !== 1'b1) begin n_fail++; $display("FAIL long_strobe_status: got %b expected 1", status_out); end
      for (int i = 0; i < 2; i++) begin
         exp = sb_next();
         do_dequeue(mid, fin, st);
         n_checks++;
         if (fin !== exp) begin n_fail++; $display("FAIL long_strobe_data[%0d]: got %h expected %h", i, fin, exp); end
      end
   endtask

   task automatic test_full();
      byte_t mid, fin, exp;
      logic  st;
      for (int v = 1; v <= 9; v++) send_byte(byte_t'(v), 10, 1'b1);
      n_checks++;
      if (status_out !== 1'b0) begin n_fail++; $display("FAIL full_status: got %b expected 0", status_out); end
      send_bit(1'b1, 10, 10);
      send_bit(1'b0, 10, 10);
      send_bit(1'b1, 10, 10);
      n_checks++;
      if (status_out !== 1'b0) begin n_fail++; $display("FAIL full_status_hold: got %b expected 0", status_out); end
      for (int i = 0; i < 10; i++) begin
         exp = sb_next();
         do_dequeue(mid, fin, st);
         n_checks++;
         if (fin !== exp) begin n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", i, fin, exp); end
         if (i == 0) begin
            n_checks++;
            if (st !== 1'b1) begin n_fail++; $display("FAIL full_status_release: got %b expected 1", st); end
         end
      end
   endtask

   task automatic test_wrap();
      byte_t mid, fin, exp, v;
      logic  st;
      for (int i = 0; i < 20; i++) begin
         v = byte_t'(i * 13 + 7);
         send_byte(v, 10, 1'b1);
         exp = sb_next();
         do_dequeue(mid, fin, st);
         n_checks++;
         if (fin !== exp) begin n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", i, fin, exp); end
      end
   endtask

   task automatic test_mid_reset();
      byte_t mid, fin, exp;
      logic  st;
      for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 10, 10);
      @(negedge clock1M);
      #100 reset = 1'b0;
      #10;
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL async_reset_data_out: got %h expected 00", data_out); end
      n_checks++;
      if (status_out !== 1'b1) begin n_fail++; $display("FAIL async_reset_status: got %b expected 1", status_out); end
      sb_q.delete();
      exp_last = 8'h00;
      wait_cycles(3);
      reset = 1'b1;
      wait_cycles(2);
      send_byte(8'h5A, 10, 1'b1);
      for (int i = 0; i < 2; i++) begin
         exp = sb_next();
         do_dequeue(mid, fin, st);
         n_checks++;
         if (fin !== exp) begin n_fail++; $display("FAIL mid_reset_data[%0d]: got %h expected %h", i, fin, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_byte_order();
      test_long_strobe();
      test_full();
      test_wrap();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_byte_queue.md
Name: serial_byte_queue

Overview:
- Serial-to-parallel receive path with byte buffering.
- Bits arrive one per write strobe, MSB first. Each completed 8-bit byte is pushed into an internal FIFO.
- A consumer pops bytes with a dequeue strobe. The popped byte is held on data_out.
- This is the top-level integration block: a deserializer front end feeding a FIFO queue.

Parameters:
- DATA_WIDTH, 8, bits per assembled word and FIFO entry width.
- DEPTH, 8, FIFO entry count (power of two).

Ports:
- clock1M  input  1  system clock, nominal 1 MHz; every register uses its rising edge.
- reset  input  1  asynchronous, active-low reset. Clears all state while 0.
- data_in  input  1  serial data bit, sampled when a write_in rising edge is detected.
- write_in  input  1  bit write strobe, level input. Only its 0->1 transition counts, whatever the high duration.
- dequeue_in  input  1  pop strobe, level input. Only its 0->1 transition counts.
- data_out  output  8  last byte popped from the FIFO.
- status_out  output  1  1 = deserializer can accept bits; 0 = a byte is complete and blocked because the FIFO is full.

Behaviour:
- Single clock domain; reset is asynchronous and active-low.
- Reset values:
  - data_out = 8'h00, status_out = 1.
  - FIFO empty.
  - Bit counter = 0, shift register = 0.
  - Edge-detect registers = 0.
- Edge detection:
  - write_in and dequeue_in are each registered once (prev flop).
  - Event = in & ~prev.
  - A strobe held high for N cycles produces exactly one event.
- Bit capture:
  - On a write event with status_out=1: shift <= {shift[6:0], data_in}; count++.
  - The first bit received becomes byte bit 7 (MSB first).
- Byte completion:
  - When the 8th bit is captured, the byte is marked pending.
  - Next cycle: if the FIFO is not full, the byte is pushed, count returns to 0 and pending clears.
  - If the FIFO is full, pending holds and status_out=0. Write events while status_out=0 are ignored (bits dropped).
  - Once a pop frees space, the pending byte is pushed on the following cycle and status_out returns to 1.
- Dequeue:
  - On a dequeue event with FIFO non-empty: data_out <= head entry; read pointer advances. Latency: data_out updates 2 clocks after dequeue_in rises (1 edge detect + 1 register).
  - data_out holds its value until the next successful pop.
  - Dequeue on an empty FIFO is ignored; data_out is unchanged.
- Simultaneous push and pop in the same cycle:
  - Both occur.
  - The count is unchanged.
  - When the FIFO is full, the pop makes room for the push in that cycle.
- FIFO implementation:
  - Circular buffer with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH.
  - Separate occupancy counter 0..DEPTH.
  - Full = count==DEPTH; empty = count==0.
- Reset asserted mid-byte or mid-operation: partial bits are discarded, FIFO contents are discarded, and all outputs return to their reset values immediately (asynchronously).
- data_in is don't-care except in cycles where a write event is taken.

Decomposition:
- Package serial_queue_pkg:
  - DATA_WIDTH, DEPTH, PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH)+1 constants.
  - byte_t typedef (logic [DATA_WIDTH-1:0]).
- One sub-module, byte_fifo:
  - Ports: push, push_data, pop, pop_data, full, empty.
  - Write-then-read-safe when push and pop coincide.
- Edge detection, shift register, bit counter and pending logic stay in serial_byte_queue.

Test Plan:
- Reset: hold reset=0 for 10 cycles, release -> data_out=8'h00, status_out=1. A dequeue strobe then leaves data_out=8'h00.
- Serial byte ordering:
  - Send bits of 8'hA5 then 8'h3C MSB first; each write_in high 10 cycles, low 10 cycles.
  - Wait, pulse dequeue_in 1 cycle -> data_out=8'hA5 two clocks later.
  - Second pulse -> data_out=8'h3C; a third pulse (empty FIFO) -> data_out stays 8'h3C.
- Long strobe: hold write_in high 50 cycles per bit for byte 8'hF0 -> exactly one byte queued; dequeue -> 8'hF0.
- Full FIFO:
  - Send 9 bytes 8'h01..8'h09 without dequeuing -> status_out=0 after the 9th byte completes.
  - Further bit strobes ignored.
  - One dequeue -> data_out=8'h01, status_out returns to 1 within 2 cycles.
  - Subsequent dequeues return 8'h02..8'h09 in order.
- Wrap-around: alternate send/dequeue of 20 distinct bytes -> every dequeue returns the matching byte; pointers wrap with no loss.
- Mid-byte reset: send 5 bits, assert reset, release, send 8'h5A, dequeue -> data_out=8'h5A; FIFO then empty.
